// File: rtl/shifter.sv
// ----------------------------------------------------------------------------
// shifter -- registered 32-bit barrel shifter with carry-out
//
// Computes LSL / LSR / ASR / ROR of Operand by Amount through a 5-stage
// logarithmic shifter and registers the result. This gives one cycle of
// latency with no combinational path from inputs to outputs, so Cout can be
// fed straight back into CIn.
//
// Ports:
//   Clk      in   1   rising-edge clock
//   Reset_n  in   1   synchronous active-low reset (Out=0, Cout=0)
//   Out      out  32  registered shift result
//   Cout     out  1   registered shifter carry-out
//   Operand  in   32  value to shift
//   Amount   in   5   shift amount 0..31
//   CIn      in   1   current carry flag (pass-through, RRX, zero shifts)
//   EN       in   1   1 = shift, 0 = pass Operand/CIn unchanged
//   STA      in   1   amount source: 0 = immediate, 1 = register
//   IR       in   2   shift type: 00 LSL, 01 LSR, 10 ASR, 11 ROR
//
// Configuration:
//   SHIFTER_RRX_EN  defined   -> immediate ROR #0 performs RRX
//                   undefined -> immediate ROR #0 passes Operand/CIn
// ----------------------------------------------------------------------------
module shifter (
    input  logic        Clk,
    input  logic        Reset_n,
    output logic [31:0] Out,
    output logic        Cout,
    input  logic [31:0] Operand,
    input  logic [4:0]  Amount,
    input  logic        CIn,
    input  logic        EN,
    input  logic        STA,
    input  logic [1:0]  IR
);

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_t;

    shift_t op;
    assign op = shift_t'(IR);

    function automatic logic [31:0] bit_rev(input logic [31:0] v);
        logic [31:0] r;
        r = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            r[i] = v[31 - i];
        end
        return r;
    endfunction

    // All shift types run through one right-shifting datapath. LSL is done
    // by bit-reversing the operand on the way in and the result on the way
    // out. The guard bit follows the last bit shifted out, so after the final
    // stage it holds Operand[n-1] (or Operand[32-n] for LSL).
    logic [31:0] stg_d [0:5];
    logic        stg_g [0:5];
    logic        sign;

    assign sign     = Operand[31];
    assign stg_d[0] = (op == SH_LSL) ? bit_rev(Operand) : Operand;
    assign stg_g[0] = 1'b0;

    for (genvar k = 0; k < 5; k++) begin : g_stage
        localparam int unsigned S = 1 << k;
        logic [31:0] shifted;
        logic [31:0] fill;

        assign shifted = stg_d[k] >> S;
        assign fill    = (op == SH_ROR)         ? (stg_d[k] << (32 - S)) :
                         ((op == SH_ASR) && sign) ? ~(32'hFFFF_FFFF >> S) :
                                                  '0;
        assign stg_d[k+1] = Amount[k] ? (shifted | fill) : stg_d[k];
        assign stg_g[k+1] = Amount[k] ? stg_d[k][S-1]   : stg_g[k];
    end

    logic [31:0] shift_out;
    logic        shift_cout;

    assign shift_out  = (op == SH_LSL) ? bit_rev(stg_d[5]) : stg_d[5];
    assign shift_cout = stg_g[5];

    logic [31:0] nxt_out;
    logic        nxt_cout;

    always_comb begin
        nxt_out  = Operand;
        nxt_cout = CIn;
        if (EN) begin
            if (Amount != 5'd0) begin
                nxt_out  = shift_out;
                nxt_cout = shift_cout;
            end else if (!STA) begin
                // Immediate #0 encodes LSR #32, ASR #32 and (optionally) RRX.
                unique case (op)
                    SH_LSR: begin
                        nxt_out  = '0;
                        nxt_cout = sign;
                    end
                    SH_ASR: begin
                        nxt_out  = {32{sign}};
                        nxt_cout = sign;
                    end
                    SH_ROR: begin
`ifdef SHIFTER_RRX_EN
                        nxt_out  = {CIn, Operand[31:1]};
                        nxt_cout = Operand[0];
`else
                        nxt_out  = Operand;
                        nxt_cout = CIn;
`endif
                    end
                    default: begin
                        nxt_out  = Operand;
                        nxt_cout = CIn;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            Out  <= '0;
            Cout <= 1'b0;
        end else begin
            Out  <= nxt_out;
            Cout <= nxt_cout;
        end
    end

endmodule

// File: tb/tb_shifter.sv
// ----------------------------------------------------------------------------
// tb_shifter -- self-checking bench for shifter
//
// Applies a table of directed vectors with hand-computed results, then
// checks reset behaviour, output latency and Cout-to-CIn feedback.
// Honours SHIFTER_RRX_EN for the immediate ROR #0 expectation.
// ----------------------------------------------------------------------------
module tb_shifter;

    logic        Clk;
    logic        Reset_n;
    logic [31:0] Out;
    logic        Cout;
    logic [31:0] Operand;
    logic [4:0]  Amount;
    logic        CIn;
    logic        EN;
    logic        STA;
    logic [1:0]  IR;

    int checks = 0;
    int errors = 0;

    shifter dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .Out     (Out),
        .Cout    (Cout),
        .Operand (Operand),
        .Amount  (Amount),
        .CIn     (CIn),
        .EN      (EN),
        .STA     (STA),
        .IR      (IR)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        string       name;
        logic        en;
        logic        sta;
        logic [1:0]  ir;
        logic [4:0]  amount;
        logic        cin;
        logic [31:0] operand;
        logic [31:0] exp_out;
        logic        exp_cout;
    } vec_t;

    localparam int NV = 26;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] got_o, input logic got_c,
                         input logic [31:0] exp_o, input logic exp_c);
        checks++;
        if (got_o !== exp_o || got_c !== exp_c) begin
            errors++;
            $display("FAIL %s: got Out=%08h Cout=%b, required Out=%08h Cout=%b",
                     name, got_o, got_c, exp_o, exp_c);
        end
    endtask

    task automatic drive(input logic en, input logic sta, input logic [1:0] ir,
                         input logic [4:0] amt, input logic cin, input logic [31:0] opnd);
        EN      = en;
        STA     = sta;
        IR      = ir;
        Amount  = amt;
        CIn     = cin;
        Operand = opnd;
    endtask

    task automatic set_vec(input int i, input string name, input logic en, input logic sta,
                           input logic [1:0] ir, input logic [4:0] amt, input logic cin,
                           input logic [31:0] opnd, input logic [31:0] eo, input logic ec);
        vecs[i].name     = name;
        vecs[i].en       = en;
        vecs[i].sta      = sta;
        vecs[i].ir       = ir;
        vecs[i].amount   = amt;
        vecs[i].cin      = cin;
        vecs[i].operand  = opnd;
        vecs[i].exp_out  = eo;
        vecs[i].exp_cout = ec;
    endtask

    logic [31:0] rrx_out;
    logic        rrx_cout;
    logic [31:0] prev_out;
    logic        prev_cout;

    initial begin
`ifdef SHIFTER_RRX_EN
        rrx_out  = 32'h8000_0000;
        rrx_cout = 1'b1;
`else
        rrx_out  = 32'h0000_0001;
        rrx_cout = 1'b1;
`endif
        //          name            en   sta   ir     amt    cin  operand        out            cout
        set_vec( 0, "lsl2",         1'b1, 1'b0, 2'b00, 5'd2,  1'b0, 32'hFFFFFFF5, 32'hFFFFFFD4, 1'b1);
        set_vec( 1, "lsr_imm0",     1'b1, 1'b0, 2'b01, 5'd0,  1'b0, 32'hFFFFFFF5, 32'h00000000, 1'b1);
        set_vec( 2, "lsr_reg0_c0",  1'b1, 1'b1, 2'b01, 5'd0,  1'b0, 32'hFFFFFFF5, 32'hFFFFFFF5, 1'b0);
        set_vec( 3, "lsr_reg0_c1",  1'b1, 1'b1, 2'b01, 5'd0,  1'b1, 32'hFFFFFFF5, 32'hFFFFFFF5, 1'b1);
        set_vec( 4, "asr3",         1'b1, 1'b0, 2'b10, 5'd3,  1'b0, 32'hFFFFFFF5, 32'hFFFFFFFE, 1'b1);
        set_vec( 5, "ror16",        1'b1, 1'b0, 2'b11, 5'd16, 1'b0, 32'hFFFFFFF5, 32'hFFF5FFFF, 1'b1);
        set_vec( 6, "en0_pass",     1'b0, 1'b0, 2'b00, 5'd31, 1'b1, 32'hFFFFFFF5, 32'hFFFFFFF5, 1'b1);
        set_vec( 7, "ror_imm0",     1'b1, 1'b0, 2'b11, 5'd0,  1'b1, 32'h00000001, rrx_out,      rrx_cout);
        set_vec( 8, "lsr4",         1'b1, 1'b0, 2'b01, 5'd4,  1'b0, 32'h12345678, 32'h01234567, 1'b1);
        set_vec( 9, "lsl31",        1'b1, 1'b0, 2'b00, 5'd31, 1'b1, 32'h00000001, 32'h80000000, 1'b0);
        set_vec(10, "lsl1",         1'b1, 1'b0, 2'b00, 5'd1,  1'b0, 32'h80000001, 32'h00000002, 1'b1);
        set_vec(11, "lsr31",        1'b1, 1'b0, 2'b01, 5'd31, 1'b1, 32'h80000000, 32'h00000001, 1'b0);
        set_vec(12, "asr31",        1'b1, 1'b0, 2'b10, 5'd31, 1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        set_vec(13, "asr_imm0_neg", 1'b1, 1'b0, 2'b10, 5'd0,  1'b0, 32'h80000000, 32'hFFFFFFFF, 1'b1);
        set_vec(14, "asr_imm0_pos", 1'b1, 1'b0, 2'b10, 5'd0,  1'b1, 32'h7FFFFFFF, 32'h00000000, 1'b0);
        set_vec(15, "ror1",         1'b1, 1'b0, 2'b11, 5'd1,  1'b0, 32'h00000001, 32'h80000000, 1'b1);
        set_vec(16, "ror4",         1'b1, 1'b0, 2'b11, 5'd4,  1'b0, 32'h12345678, 32'h81234567, 1'b1);
        set_vec(17, "ror31",        1'b1, 1'b0, 2'b11, 5'd31, 1'b1, 32'h80000000, 32'h00000001, 1'b0);
        set_vec(18, "lsl_imm0",     1'b1, 1'b0, 2'b00, 5'd0,  1'b0, 32'h12345678, 32'h12345678, 1'b0);
        set_vec(19, "lsr1",         1'b1, 1'b0, 2'b01, 5'd1,  1'b0, 32'hFFFFFFF5, 32'h7FFFFFFA, 1'b1);
        set_vec(20, "asr1_pos",     1'b1, 1'b0, 2'b10, 5'd1,  1'b1, 32'h12345678, 32'h091A2B3C, 1'b0);
        set_vec(21, "lsl4",         1'b1, 1'b0, 2'b00, 5'd4,  1'b0, 32'h12345678, 32'h23456780, 1'b1);
        set_vec(22, "ror_reg0",     1'b1, 1'b1, 2'b11, 5'd0,  1'b0, 32'h00000001, 32'h00000001, 1'b0);
        set_vec(23, "asr_reg0",     1'b1, 1'b1, 2'b10, 5'd0,  1'b1, 32'h80000000, 32'h80000000, 1'b1);
        set_vec(24, "en0_lsr",      1'b0, 1'b0, 2'b01, 5'd0,  1'b0, 32'h0000ABCD, 32'h0000ABCD, 1'b0);
        set_vec(25, "lsr16",        1'b1, 1'b1, 2'b01, 5'd16, 1'b1, 32'hABCD1234, 32'h0000ABCD, 1'b0);

        // Reset state
        Reset_n = 1'b0;
        drive(1'b1, 1'b0, 2'b00, 5'd1, 1'b1, 32'hDEADBEEF);
        repeat (2) @(posedge Clk);
        #1;
        check("reset_state", Out, Cout, 32'h0, 1'b0);

        @(negedge Clk);
        Reset_n = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < NV; i++) begin
            @(negedge Clk);
            drive(vecs[i].en, vecs[i].sta, vecs[i].ir, vecs[i].amount, vecs[i].cin, vecs[i].operand);
            @(posedge Clk);
            #1;
            check(vecs[i].name, Out, Cout, vecs[i].exp_out, vecs[i].exp_cout);
        end

        // Latency: new inputs must not reach Out before the next edge
        @(negedge Clk);
        drive(1'b1, 1'b0, 2'b00, 5'd4, 1'b0, 32'h00000001);
        @(posedge Clk);
        #1;
        check("lat_setup", Out, Cout, 32'h00000010, 1'b0);
        @(negedge Clk);
        drive(1'b1, 1'b0, 2'b11, 5'd1, 1'b1, 32'h00000003);
        #2;
        check("lat_hold", Out, Cout, 32'h00000010, 1'b0);
        @(posedge Clk);
        #1;
        check("lat_update", Out, Cout, 32'h80000001, 1'b1);

        // Reset overrides an active shift, then release gives a result next edge
        @(negedge Clk);
        Reset_n = 1'b0;
        drive(1'b1, 1'b0, 2'b00, 5'd2, 1'b0, 32'hFFFFFFF5);
        @(posedge Clk);
        #1;
        check("reset_override", Out, Cout, 32'h0, 1'b0);
        @(negedge Clk);
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;
        check("reset_release", Out, Cout, 32'hFFFFFFD4, 1'b1);

        // Cout fed back as CIn across consecutive pass-through cycles
        @(negedge Clk);
        drive(1'b1, 1'b0, 2'b01, 5'd1, 1'b0, 32'h00000001);
        @(posedge Clk);
        #1;
        check("fb_lsr1", Out, Cout, 32'h00000000, 1'b1);
        @(negedge Clk);
        drive(1'b0, 1'b0, 2'b00, 5'd0, Cout, 32'h00000055);
        @(posedge Clk);
        #1;
        check("fb_pass", Out, Cout, 32'h00000055, 1'b1);
        @(negedge Clk);
        drive(1'b1, 1'b1, 2'b11, 5'd0, Cout, 32'h00000066);
        @(posedge Clk);
        #1;
        check("fb_reg0", Out, Cout, 32'h00000066, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shifter.md
SHIFTER -- requirements
Module: shifter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: Clk and Reset_n.
REQ-002 Clk  input  1  rising-edge clock; all state updates on this edge.
REQ-003 Reset_n  input  1  synchronous active-low reset, sampled on rising Clk.
REQ-004 Out  output  32  registered shift result.
REQ-005 Cout  output  1  registered shifter carry-out.
REQ-006 Operand  input  32  value to shift.
REQ-007 Amount  input  5  shift amount, 0..31.
REQ-008 CIn  input  1  current carry flag; used for pass-through, RRX and register-mode zero shifts.
REQ-009 EN  input  1  1 = shift, 0 = pass Operand unchanged.
REQ-010 STA  input  1  amount source: 0 = immediate-encoded, 1 = register-specified.
REQ-011 IR  input  2  shift type: 00 LSL, 01 LSR, 10 ASR, 11 ROR.

Function
REQ-012 Out/Cout SHALL be registered with 1-cycle latency: inputs sampled at edge N appear after edge N; there is no combinational path from any input to Out or Cout, so Cout may be fed back to CIn.
REQ-013 EN=0 SHALL load Out=Operand and Cout=CIn, regardless of IR, STA and Amount.
REQ-014 LSL, n=Amount>0: Out=Operand<<n, zero fill; Cout=Operand[32-n].
REQ-015 LSR, n>0: Out=Operand>>n, zero fill; Cout=Operand[n-1].
REQ-016 ASR, n>0: Out=Operand>>n, Operand[31] fill; Cout=Operand[n-1].
REQ-017 ROR, n>0: Out=Operand rotated right by n; Cout=Operand[n-1].
REQ-018 Amount=0 with STA=1, any IR: Out=Operand, Cout=CIn.
REQ-019 Amount=0 with STA=0 and IR=LSL: Out=Operand, Cout=CIn.
REQ-020 Amount=0 with STA=0 and IR=LSR means LSR #32: Out=0, Cout=Operand[31].
REQ-021 Amount=0 with STA=0 and IR=ASR means ASR #32: every Out bit=Operand[31], Cout=Operand[31].
REQ-022 Amount=0 with STA=0 and IR=ROR SHALL behave as defined in REQ-026.
REQ-023 Arithmetic is purely combinational ahead of the output register, implemented as a log-shifter of 5 stages; no multi-cycle operation.

Reset
REQ-024 When Reset_n=0 at a rising Clk edge, Out SHALL load 32'h00000000 and Cout SHALL load 0, overriding all other inputs.
REQ-025 The first edge with Reset_n=1 SHALL capture a normal result; there are no other state elements.

Configuration
REQ-026 Macro SHIFTER_RRX_EN selects the ROR #0 behaviour when STA=0:
- Defined: RRX, with Out={CIn, Operand[31:1]} and Cout=Operand[0].
- Undefined: Out=Operand and Cout=CIn.

Verification
REQ-027 Operand=32'hFFFFFFF5, EN=1, STA=0, IR=00, Amount=2 -> next cycle Out=32'hFFFFFFD4, Cout=1.
REQ-028 Same Operand, IR=01, Amount=0, STA=0 -> Out=32'h00000000, Cout=1; with STA=1 -> Out=32'hFFFFFFF5, Cout=CIn.
REQ-029 Same Operand, IR=10, Amount=3 -> Out=32'hFFFFFFFE, Cout=1; IR=11, Amount=16 -> Out=32'hFFF5FFFF, Cout=1.
REQ-030 EN=0, IR=00, Amount=31, CIn=1 -> Out=32'hFFFFFFF5, Cout=1.
REQ-031 Operand=32'h00000001, IR=11, Amount=0, STA=0, CIn=1:
- With SHIFTER_RRX_EN: Out=32'h80000000, Cout=1.
- Without: Out=32'h00000001, Cout=1.
REQ-032 Reset_n=0 while EN=1 and Operand nonzero -> Out=0, Cout=0 on that edge; release -> correct result one edge later.
